// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full and overflow logic of an async FIFO; FIFO_WPTR_LEVEL_EN adds w_level/w_almost_full
module fifo_wptr_full #(
    parameter int PTR_WIDTH    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic                 w_inc,
    input  logic [PTR_WIDTH:0]   r_ptr_gray,
    output logic                 w_en,
    output logic [PTR_WIDTH-1:0] w_addr,
    output logic [PTR_WIDTH:0]   w_ptr_gray,
    output logic                 w_full,
`ifdef FIFO_WPTR_LEVEL_EN
    output logic                 w_almost_full,
    output logic [PTR_WIDTH:0]   w_level,
`endif
    output logic                 w_overflow
);
    localparam logic [PTR_WIDTH:0] TOP2 = (PTR_WIDTH + 1)'(3) << (PTR_WIDTH - 1);

    logic [PTR_WIDTH:0] rq_q [2];
    logic [PTR_WIDTH:0] w_bin_q, w_bin_d;
    logic [PTR_WIDTH:0] w_ptr_gray_q, w_ptr_gray_d;
    logic               w_full_q, w_full_d;
    logic               w_overflow_q, w_overflow_d;

    // two-stage synchroniser: rq_q[0] is rq1, rq_q[1] is rq2; rq_q[0] is the value rq2 takes this edge
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rq_q[0] <= '0;
            rq_q[1] <= '0;
        end else begin
            rq_q[0] <= r_ptr_gray;
            rq_q[1] <= rq_q[0];
        end
    end

    // accept a push, advance the pointer and test full against the incoming rq2 value
    always_comb begin
        w_en         = w_inc & ~w_full_q;
        w_bin_d      = w_bin_q + (PTR_WIDTH + 1)'(w_en);
        w_ptr_gray_d = w_bin_d ^ (w_bin_d >> 1);
        w_full_d     = w_ptr_gray_d == (rq_q[0] ^ TOP2);
        w_overflow_d = w_overflow_q | (w_inc & w_full_q);
    end

    // pointer, full and sticky overflow state
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_bin_q      <= '0;
            w_ptr_gray_q <= '0;
            w_full_q     <= 1'b0;
            w_overflow_q <= 1'b0;
        end else begin
            w_bin_q      <= w_bin_d;
            w_ptr_gray_q <= w_ptr_gray_d;
            w_full_q     <= w_full_d;
            w_overflow_q <= w_overflow_d;
        end
    end

    assign w_addr     = w_bin_q[PTR_WIDTH-1:0];
    assign w_ptr_gray = w_ptr_gray_q;
    assign w_full     = w_full_q;
    assign w_overflow = w_overflow_q;

`ifdef FIFO_WPTR_LEVEL_EN
    logic [PTR_WIDTH:0] w_level_q, w_level_d;
    logic               w_afull_q, w_afull_d;

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // occupancy as seen against the incoming rq2 value, and its threshold flag
    always_comb begin
        w_level_d = w_bin_d - gray2bin(rq_q[0]);
        w_afull_d = w_level_d >= (PTR_WIDTH + 1)'(AFULL_THRESH);
    end

    // level and almost-full registers
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_level_q <= '0;
            w_afull_q <= 1'b0;
        end else begin
            w_level_q <= w_level_d;
            w_afull_q <= w_afull_d;
        end
    end

    assign w_level       = w_level_q;
    assign w_almost_full = w_afull_q;
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scoreboard bench for the write-side pointer/full block
module tb_fifo_wptr_full;
    logic       w_clk = 1'b0;
    logic       w_rst;
    logic       w_inc;
    logic [4:0] r_ptr_gray;
    logic       w_en;
    logic [3:0] w_addr;
    logic [4:0] w_ptr_gray;
    logic       w_full;
    logic       w_overflow;
`ifdef FIFO_WPTR_LEVEL_EN
    logic       w_almost_full;
    logic [4:0] w_level;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q [$];
    logic [3:0] e;

    fifo_wptr_full #(.PTR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .w_clk(w_clk),
        .w_rst(w_rst),
        .w_inc(w_inc),
        .r_ptr_gray(r_ptr_gray),
        .w_en(w_en),
        .w_addr(w_addr),
        .w_ptr_gray(w_ptr_gray),
        .w_full(w_full),
`ifdef FIFO_WPTR_LEVEL_EN
        .w_almost_full(w_almost_full),
        .w_level(w_level),
`endif
        .w_overflow(w_overflow)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic do_reset();
        w_rst = 1'b1;
        w_inc = 1'b0;
        r_ptr_gray = '0;
        exp_q.delete();
        repeat (2) @(posedge w_clk);
        #1 w_rst = 1'b0;
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        w_inc = 1'b1;
        r_ptr_gray = 5'b10101;
        #1;
        n_cmp++; if (w_ptr_gray !== 5'd0) begin n_bad++; $display("FAIL rst_gray: got %b want 00000", w_ptr_gray); end
        n_cmp++; if (w_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", w_full); end
        n_cmp++; if (w_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", w_overflow); end
        n_cmp++; if (w_en !== 1'b1) begin n_bad++; $display("FAIL rst_en_follows_inc: got %b want 1", w_en); end
        @(posedge w_clk); #1;
        n_cmp++; if (w_addr !== 4'd0) begin n_bad++; $display("FAIL rst_push_discarded: got %0d want 0", w_addr); end
`ifdef FIFO_WPTR_LEVEL_EN
        n_cmp++; if (w_level !== 5'd0 || w_almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_level: got %0d/%b want 0/0", w_level, w_almost_full); end
`endif
        w_inc = 1'b0;
        r_ptr_gray = '0;
        w_rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            w_inc = 1'b1;
            exp_q.push_back(4'(i));
            #1;
            n_cmp++;
            if (w_en !== 1'b1) begin n_bad++; $display("FAIL fill_en[%0d]: got %b want 1", i, w_en); end
            else begin
                e = exp_q.pop_front();
                n_cmp++; if (w_addr !== e) begin n_bad++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, w_addr, e); end
            end
            @(posedge w_clk); #1;
            n_cmp++; if (w_full !== (i == 15)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, w_full, i == 15); end
        end
        w_inc = 1'b0;
        n_cmp++; if (w_ptr_gray !== 5'b11000) begin n_bad++; $display("FAIL fill_gray: got %b want 11000", w_ptr_gray); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fill_sb_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        n_cmp++; if (w_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %b want 0", w_overflow); end
        for (int i = 0; i < 3; i++) begin
            w_inc = 1'b1;
            #1;
            n_cmp++; if (w_en !== 1'b0) begin n_bad++; $display("FAIL ovf_en[%0d]: got %b want 0", i, w_en); end
            @(posedge w_clk); #1;
            n_cmp++; if (w_ptr_gray !== 5'b11000) begin n_bad++; $display("FAIL ovf_hold[%0d]: got %b want 11000", i, w_ptr_gray); end
            n_cmp++; if (w_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set[%0d]: got %b want 1", i, w_overflow); end
        end
        w_inc = 1'b0;
        repeat (3) @(posedge w_clk);
        #1;
        n_cmp++; if (w_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", w_overflow); end
    endtask

    task automatic test_release();
        r_ptr_gray = 5'b00001;
        @(posedge w_clk); #1;
        n_cmp++; if (w_full !== 1'b1) begin n_bad++; $display("FAIL rel_edge1: got %b want 1", w_full); end
        @(posedge w_clk); #1;
        n_cmp++; if (w_full !== 1'b0) begin n_bad++; $display("FAIL rel_edge2: got %b want 0", w_full); end
        w_inc = 1'b1;
        exp_q.push_back(4'd0);
        #1;
        n_cmp++;
        if (w_en !== 1'b1) begin n_bad++; $display("FAIL rel_en: got %b want 1", w_en); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (w_addr !== e) begin n_bad++; $display("FAIL rel_addr: got %0d want %0d", w_addr, e); end
        end
        @(posedge w_clk); #1;
        w_inc = 1'b0;
        n_cmp++; if (w_full !== 1'b1) begin n_bad++; $display("FAIL rel_refull: got %b want 1", w_full); end
        n_cmp++; if (w_ptr_gray !== 5'b11001) begin n_bad++; $display("FAIL rel_gray: got %b want 11001", w_ptr_gray); end
        n_cmp++; if (w_overflow !== 1'b1) begin n_bad++; $display("FAIL rel_ovf_kept: got %b want 1", w_overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            w_inc = 1'b1;
            r_ptr_gray = g5(k >= 10 ? k - 10 : 0);
            exp_q.push_back(4'(k));
            #1;
            n_cmp++;
            if (w_en !== 1'b1) begin n_bad++; $display("FAIL b2b_en[%0d]: got %b want 1", k, w_en); end
            else begin
                e = exp_q.pop_front();
                n_cmp++; if (w_addr !== e) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, w_addr, e); end
            end
            @(posedge w_clk); #1;
            n_cmp++; if (w_full !== 1'b0) begin n_bad++; $display("FAIL b2b_full[%0d]: got %b want 0", k, w_full); end
        end
        w_inc = 1'b0;
        n_cmp++; if (w_ptr_gray !== g5(40)) begin n_bad++; $display("FAIL b2b_gray: got %b want %b", w_ptr_gray, g5(40)); end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            w_inc = 1'b1;
            exp_q.push_back(4'(i));
            #1;
            if (w_en === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++; if (w_addr !== e) begin n_bad++; $display("FAIL mid_addr[%0d]: got %0d want %0d", i, w_addr, e); end
            end
            @(posedge w_clk); #1;
        end
        n_cmp++; if (w_ptr_gray !== g5(7)) begin n_bad++; $display("FAIL mid_pre_gray: got %b want %b", w_ptr_gray, g5(7)); end
        #2 w_rst = 1'b1;
        #1;
        n_cmp++; if (w_ptr_gray !== 5'd0 || w_addr !== 4'd0) begin n_bad++; $display("FAIL mid_rst_ptr: got %b/%0d want 00000/0", w_ptr_gray, w_addr); end
        n_cmp++; if (w_full !== 1'b0 || w_overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got %b%b want 00", w_full, w_overflow); end
        exp_q.delete();
        @(posedge w_clk); #1;
        w_rst = 1'b0;
        exp_q.push_back(4'd0);
        #1;
        n_cmp++;
        if (w_en !== 1'b1) begin n_bad++; $display("FAIL mid_post_en: got %b want 1", w_en); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (w_addr !== e) begin n_bad++; $display("FAIL mid_post_addr: got %0d want %0d", w_addr, e); end
        end
        @(posedge w_clk); #1;
        w_inc = 1'b0;
        n_cmp++; if (w_ptr_gray !== 5'b00001) begin n_bad++; $display("FAIL mid_post_gray: got %b want 00001", w_ptr_gray); end
    endtask

`ifdef FIFO_WPTR_LEVEL_EN
    task automatic test_level();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            w_inc = 1'b1;
            #1;
            @(posedge w_clk); #1;
            n_cmp++; if (w_level !== 5'(i + 1)) begin n_bad++; $display("FAIL lvl[%0d]: got %0d want %0d", i, w_level, i + 1); end
            n_cmp++; if (w_almost_full !== (i == 11)) begin n_bad++; $display("FAIL afull[%0d]: got %b want %b", i, w_almost_full, i == 11); end
        end
        w_inc = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_back_to_back();
        test_midreset();
`ifdef FIFO_WPTR_LEVEL_EN
        test_level();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
